// File: rtl/dmem_responder_pkg.sv
// ============================================================================
// Module   : dmem_map_pkg
// Brief    : Address map and STATUS layout for the data-memory responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_map_pkg;

   localparam int IO_SEL_BIT = 31;

   localparam logic [2:0] REG_TX       = 3'd0;
   localparam logic [2:0] REG_STATUS   = 3'd1;
   localparam logic [2:0] REG_CYCLE_LO = 3'd2;
   localparam logic [2:0] REG_CYCLE_HI = 3'd3;

   localparam int ST_EMPTY     = 0;
   localparam int ST_FULL      = 1;
   localparam int ST_OVF       = 2;
   localparam int ST_COUNT_LSB = 4;

   // The count field is only four bits wide, so deeper FIFOs show 15.
   function automatic logic [31:0] pack_status(input logic [31:0] count,
                                               input logic ovf,
                                               input logic full,
                                               input logic empty);
      logic [31:0] s;
      logic [3:0]  c4;
      c4 = (count > 32'd15) ? 4'd15 : count[3:0];
      s = '0;
      s[ST_EMPTY]            = empty;
      s[ST_FULL]             = full;
      s[ST_OVF]              = ovf;
      s[ST_COUNT_LSB +: 4]   = c4;
      return s;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_responder_if.sv
// ============================================================================
// Module   : dmem_responder_if
// Brief    : Core data port plus console drain handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_responder_if;
   logic [31:0] daddr;
   logic [31:0] dwdata;
   logic [3:0]  dwe;
   logic [31:0] drdata;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   modport master (
      output daddr, dwdata, dwe, tx_ready,
      input  drdata, tx_data, tx_valid
   );

   modport slave (
      input  daddr, dwdata, dwe, tx_ready,
      output drdata, tx_data, tx_valid
   );
endinterface

`default_nettype wire

// File: rtl/dmem_responder_tx_fifo.sv
// ============================================================================
// Module   : tx_fifo
// Brief    : Circular console FIFO; push while full is accepted only with a pop.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_rd_ptr;
   logic [AW-1:0]    r_wr_ptr;
   logic [AW:0]      r_count;
   logic             w_pop;
   logic             w_push;

   assign empty  = (r_count == '0);
   assign full   = (r_count == (AW+1)'(DEPTH));
   assign count  = r_count;
   assign head   = empty ? '0 : r_mem[r_rd_ptr];
   assign w_pop  = pop && !empty;
   assign w_push = push && (!full || w_pop);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage has no reset; the empty flag masks stale entries.
   always_ff @(posedge clk) begin
      if (reset && w_push) r_mem[r_wr_ptr] <= push_data;
   end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module   : dmem_responder
// Brief    : Byte-enabled RAM plus console/status/cycle-counter I/O page.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder
   import dmem_map_pkg::*;
#(
   parameter int RAM_WORDS  = 1024,
   parameter int FIFO_DEPTH = 8
) (
   input  logic              clk,
   input  logic              reset,
   dmem_responder_if.slave   bus
);
   localparam int C_RAM_AW = $clog2(RAM_WORDS);
   localparam int C_CNT_W  = $clog2(FIFO_DEPTH) + 1;

   logic [31:0]         r_ram [RAM_WORDS];
   logic [63:0]         r_cycle;
   logic [31:0]         r_cycle_hi_shadow;
   logic                r_overflow;

   logic                w_io_sel;
   logic [C_RAM_AW-1:0] w_word;
   logic [2:0]          w_reg;
   logic                w_tx_wr;
   logic                w_pop;
   logic                w_ovf_set;
   logic                w_ovf_clr;
   logic                w_lo_read;
   logic                w_empty;
   logic                w_full;
   logic [C_CNT_W-1:0]  w_count;
   logic                w_unused;

   assign w_io_sel  = bus.daddr[IO_SEL_BIT];
   assign w_word    = bus.daddr[C_RAM_AW+1:2];
   assign w_reg     = bus.daddr[4:2];
   assign w_tx_wr   = w_io_sel && (w_reg == REG_TX) && bus.dwe[0];
   assign w_pop     = bus.tx_valid && bus.tx_ready;
   assign w_ovf_set = w_tx_wr && w_full && !w_pop;
   assign w_ovf_clr = w_io_sel && (w_reg == REG_STATUS) && bus.dwe[0] && bus.dwdata[ST_OVF];
   assign w_lo_read = w_io_sel && (w_reg == REG_CYCLE_LO) && (bus.dwe == 4'b0000);
   assign w_unused  = ^{bus.daddr[30:C_RAM_AW+2], bus.daddr[1:0]};

   tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_tx_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (w_tx_wr),
      .push_data (bus.dwdata[7:0]),
      .pop       (w_pop),
      .head      (bus.tx_data),
      .empty     (w_empty),
      .full      (w_full),
      .count     (w_count)
   );

   assign bus.tx_valid = !w_empty;

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (!w_io_sel && bus.dwe[i]) r_ram[w_word][8*i +: 8] <= bus.dwdata[8*i +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cycle           <= '0;
         r_cycle_hi_shadow <= '0;
         r_overflow        <= 1'b0;
      end else begin
         r_cycle <= r_cycle + 64'd1;
         if (w_lo_read) r_cycle_hi_shadow <= r_cycle[63:32];
         // Set wins over a same-cycle clear.
         if (w_ovf_set)      r_overflow <= 1'b1;
         else if (w_ovf_clr) r_overflow <= 1'b0;
      end
   end

   always_comb begin
      bus.drdata = '0;
      if (!w_io_sel) begin
         bus.drdata = r_ram[w_word];
      end else begin
         case (w_reg)
            REG_STATUS:   bus.drdata = pack_status(32'(w_count), r_overflow, w_full, w_empty);
            REG_CYCLE_LO: bus.drdata = r_cycle[31:0];
            REG_CYCLE_HI: bus.drdata = r_cycle_hi_shadow;
            default:      bus.drdata = '0;
         endcase
      end
   end

endmodule

`default_nettype wire
